sudoku_check_sequencer: RTL and testbench
=========================================

Name: sudoku_check_sequencer

Overview:
- Board-load and validity-check controller for the handwritten-sudoku solver.
- Captures an 81-cell board streamed in on reading/data and holds it in a local register array.
- Time-shares one external 9-cell group checker across all 27 sudoku groups (9 rows, 9 columns, 9 boxes) and reports valid/done.
- Replaces the 27 parallel checker instances with a single sequenced checker.

Parameters:
- CHK_LAT, default 1: checker latency in cycles from chk_req to a valid chk_ok; legal range 0..7.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- reading  input  1  cell strobe; data is captured on each cycle it is high
- data  input  11  cell word; bit10=1 means empty, bits[9:0] hold the value
- chk_req  output  1  one-cycle pulse; grp_cells is valid from this cycle
- grp_sel  output  5  current group index 0..26
- grp_cells  output  99  the 9 cells of the group; slot k occupies bits[11k+10:11k]
- chk_ok  input  1  checker result, sampled CHK_LAT cycles after chk_req
- busy  output  1  high while the check sequence runs
- done  output  1  high from check completion until the next load starts
- valid  output  1  board-valid result; meaningful only while done=1
- bad_group  output  5  first failing group index; 31 if no group failed

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state LOAD, cell count 0, group index 0, all 81 cells = 11'h400, chk_req=0, grp_sel=0, busy=0, done=0, valid=0, bad_group=31.
- Cell addressing: row-major, cell index n → row n/9, col n%9.
- Group mapping:
  - g=0..8: row g; slot k = col k.
  - g=9..17: column g-9; slot k = row k.
  - g=18..26: box b=g-18; rows 3*(b/3)..+2, cols 3*(b%3)..+2; slots row-major within the box.
- grp_cells is combinational from the board and grp_sel, and stays stable from chk_req through the chk_ok sample.
- States: LOAD, ISSUE, WAIT, DONE.
- LOAD:
  - reading=1: write data to cell n, n++.
  - reading=0: hold; gaps of any length are allowed.
  - On the write of n=80: n←0, g←0, busy←1 next cycle, go ISSUE.
- ISSUE:
  - chk_req=1 and grp_sel=g for exactly one cycle.
  - CHK_LAT=0: sample chk_ok in this same cycle and evaluate (see evaluation rules).
  - CHK_LAT>0: load the latency counter, go WAIT.
- WAIT: count down; sample chk_ok in the cycle CHK_LAT after chk_req, then evaluate.
- Evaluation rules:
  - chk_ok=0: bad_group←g, valid←0, go DONE; no further requests (early abort).
  - chk_ok=1 and g=26: valid←1, bad_group←31, go DONE.
  - otherwise: g++, go ISSUE.
- DONE:
  - busy=0, done=1; valid and bad_group held.
  - reading=1 in DONE clears done and valid, sets bad_group←31, and writes data as cell 0 (n←1); state is LOAD.
- reading=1 in ISSUE or WAIT is ignored; data is dropped and the board is unchanged.
- All-pass latency: 27*(CHK_LAT+1) cycles from busy rising to done rising (54 for CHK_LAT=1).
- rst_n low at any time, including mid-check: every register returns to its reset value immediately, and any in-flight chk_ok is discarded.

Optional Feature:
- Macro: SUDOKU_SEQ_FAIL_MASK_EN.
- Defined:
  - Adds output fail_mask[26:0], cleared on reset and on load start.
  - Bit g is set when group g returns chk_ok=0.
  - No early abort: all 27 groups are always checked, so the sequence always takes the full 27*(CHK_LAT+1) cycles.
  - valid = (fail_mask==0); bad_group = lowest failing index, or 31 if none.
- Undefined: no fail_mask port; early abort as described in Behaviour.

Test Plan:
- All 81 cells 11'h400, CHK_LAT=1, stub checker always ok → 27 chk_req pulses at grp_sel 0..26, done rises 54 cycles after busy, valid=1, bad_group=31.
- Solved grid with reading gaps of 5 cycles at cells 40 and 80 → count holds across each gap; group 20 slots equal cells (0,6),(0,7),(0,8),(1,6),…,(2,8); group 13 slots equal column 4 rows 0..8.
- Stub fails group 12 → exactly 13 requests, then done=1, valid=0, bad_group=12; chk_req stays 0 afterwards.
- CHK_LAT=0 and CHK_LAT=3, all ok → done at 27 and 108 cycles respectively; chk_ok is sampled only at the specified cycle (stub drives garbage on every other cycle).
- rst_n pulsed low during WAIT of group 7 → outputs return to reset values immediately, board reads back empty, and a fresh 81-cell load passes; reading pulses during busy leave the board unchanged.
- SUDOKU_SEQ_FAIL_MASK_EN defined, stub fails groups 3 and 20 → 27 requests, fail_mask=27'h0100008, valid=0, bad_group=3.

Source files
------------

// File: rtl/sudoku_check_sequencer.sv
// Loads an 81-cell board, then walks all 27 groups through one shared checker; done after 27*(CHK_LAT+1) cycles if all pass.
// No backpressure: reading while busy is dropped. SUDOKU_SEQ_FAIL_MASK_EN adds fail_mask and disables early abort.
module sudoku_check_sequencer #(
  parameter int CHK_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reading,
  input  logic [10:0] data,
  output logic        chk_req,
  output logic [4:0]  grp_sel,
  output logic [98:0] grp_cells,
  input  logic        chk_ok,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [4:0]  bad_group
`ifdef SUDOKU_SEQ_FAIL_MASK_EN
  ,
  output logic [26:0] fail_mask
`endif
);

  typedef enum logic [1:0] {LOAD, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] LAT_M1 = (CHK_LAT > 0) ? 3'(CHK_LAT - 1) : 3'd0;
`ifdef SUDOKU_SEQ_FAIL_MASK_EN
  localparam bit ABORT_EN = 1'b0;
`else
  localparam bit ABORT_EN = 1'b1;
`endif

  state_t      state, state_nxt;
  logic [10:0] cells [81];
  logic [6:0]  cnt;
  logic [4:0]  grp;
  logic [2:0]  lat_cnt;
  logic        load_wr;
  logic        restart;
  logic        eval;

  // Board cell feeding slot k of group g (row-major board index).
  function automatic logic [6:0] cell_idx(input logic [4:0] g, input int k);
    int r, c, b, br, bc, idx;
    r  = 0;
    c  = 0;
    b  = 0;
    br = 0;
    bc = 0;
    if (g < 5'd9) begin
      r = int'(g);
      c = k;
    end else if (g < 5'd18) begin
      r = k;
      c = int'(g) - 9;
    end else begin
      b  = int'(g) - 18;
      br = (b >= 6) ? 2 : ((b >= 3) ? 1 : 0);
      bc = b - 3 * br;
      r  = 3 * br + k / 3;
      c  = 3 * bc + k % 3;
    end
    idx = r * 9 + c;
    if (idx > 80) idx = 0;
    return 7'(idx);
  endfunction

  always_comb begin
    grp_cells = '0;
    for (int k = 0; k < 9; k++) begin
      grp_cells[11*k +: 11] = cells[cell_idx(grp, k)];
    end
  end

  assign chk_req = (state == ISSUE);
  assign grp_sel = grp;

  always_comb begin
    state_nxt = state;
    load_wr   = 1'b0;
    restart   = 1'b0;
    eval      = 1'b0;
    case (state)
      LOAD: begin
        if (reading) begin
          load_wr = 1'b1;
          if (cnt == 7'd80) state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (CHK_LAT == 0) eval = 1'b1;
        else              state_nxt = WAIT;
      end
      WAIT: begin
        if (lat_cnt == 3'd0) eval = 1'b1;
      end
      DONE: begin
        if (reading) begin
          restart   = 1'b1;
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
    if (eval) begin
      if ((grp == 5'd26) || (ABORT_EN && !chk_ok)) state_nxt = DONE;
      else                                         state_nxt = ISSUE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 81; i++) cells[i] <= 11'h400;
      cnt       <= '0;
      grp       <= '0;
      lat_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
      bad_group <= 5'd31;
`ifdef SUDOKU_SEQ_FAIL_MASK_EN
      fail_mask <= '0;
`endif
    end else begin
      if (load_wr) begin
        cells[cnt] <= data;
        if (cnt == 7'd80) begin
          cnt  <= '0;
          grp  <= '0;
          busy <= 1'b1;
        end else begin
          cnt <= cnt + 7'd1;
        end
      end
      // A write arriving in DONE is the first cell of the next board.
      if (restart) begin
        cells[0]  <= data;
        cnt       <= 7'd1;
        done      <= 1'b0;
        valid     <= 1'b0;
        bad_group <= 5'd31;
`ifdef SUDOKU_SEQ_FAIL_MASK_EN
        fail_mask <= '0;
`endif
      end
      if (state == ISSUE)        lat_cnt <= LAT_M1;
      else if (lat_cnt != 3'd0)  lat_cnt <= lat_cnt - 3'd1;
      if (eval) begin
        // Groups are visited in order, so the first failure is the lowest index.
        if (!chk_ok && (bad_group == 5'd31)) bad_group <= grp;
`ifdef SUDOKU_SEQ_FAIL_MASK_EN
        if (!chk_ok) fail_mask[grp] <= 1'b1;
`endif
        if (state_nxt == DONE) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          valid <= chk_ok && (bad_group == 5'd31);
        end else begin
          grp <= grp + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sudoku_check_sequencer.sv
// Directed bench: three sequencers (CHK_LAT 0/1/3) share one load stream; stub checkers answer only on the sample cycle.
`timescale 1ns/1ps
module tb_sudoku_check_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reading = 1'b0;
  logic [10:0] data = '0;
  always #5 clk = ~clk;

  logic        chk_req0, chk_req1, chk_req3;
  logic [4:0]  grp_sel0, grp_sel1, grp_sel3;
  logic [98:0] grp_cells0, grp_cells1, grp_cells3;
  logic        ok0 = 1'b0, ok1 = 1'b0, ok3 = 1'b0;
  logic        busy0, busy1, busy3, done0, done1, done3, valid0, valid1, valid3;
  logic [4:0]  bad0, bad1, bad3;
`ifdef SUDOKU_SEQ_FAIL_MASK_EN
  logic [26:0] mask0, mask1, mask3;
`endif

  sudoku_check_sequencer #(.CHK_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .reading(reading), .data(data), .chk_req(chk_req0),
    .grp_sel(grp_sel0), .grp_cells(grp_cells0), .chk_ok(ok0), .busy(busy0), .done(done0),
    .valid(valid0), .bad_group(bad0)
`ifdef SUDOKU_SEQ_FAIL_MASK_EN
    , .fail_mask(mask0)
`endif
  );
  sudoku_check_sequencer #(.CHK_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .reading(reading), .data(data), .chk_req(chk_req1),
    .grp_sel(grp_sel1), .grp_cells(grp_cells1), .chk_ok(ok1), .busy(busy1), .done(done1),
    .valid(valid1), .bad_group(bad1)
`ifdef SUDOKU_SEQ_FAIL_MASK_EN
    , .fail_mask(mask1)
`endif
  );
  sudoku_check_sequencer #(.CHK_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .reading(reading), .data(data), .chk_req(chk_req3),
    .grp_sel(grp_sel3), .grp_cells(grp_cells3), .chk_ok(ok3), .busy(busy3), .done(done3),
    .valid(valid3), .bad_group(bad3)
`ifdef SUDOKU_SEQ_FAIL_MASK_EN
    , .fail_mask(mask3)
`endif
  );

  // Stub checkers: correct answer on the sample cycle, the opposite answer on every other cycle.
  logic [26:0] fail0 = '0, fail1 = '0, fail3 = '0;
  logic        hist1 = 1'b0;
  logic [2:0]  hist3 = '0;
  always @(posedge clk) begin
    hist1 <= chk_req1;
    hist3 <= {hist3[1:0], chk_req3};
  end
  always @(negedge clk) begin
    ok0 = chk_req0 ? !fail0[grp_sel0] : fail0[grp_sel0];
    ok1 = hist1    ? !fail1[grp_sel1] : fail1[grp_sel1];
    ok3 = hist3[2] ? !fail3[grp_sel3] : fail3[grp_sel3];
  end

  int errors = 0;
  int checks = 0;
  int b0, b1, b3, d0, d1, d3, rq0, rq1, rq3, eg0, eg1, eg3, seqerr;
  logic [98:0] cap9, cap13, cap20;
  logic [10:0] bd [81];
  logic [98:0] empty_grp = {9{11'h400}};
  bit found;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [98:0] exp_col(input int c);
    logic [98:0] e;
    e = '0;
    for (int k = 0; k < 9; k++) e[11*k +: 11] = bd[k*9 + c];
    return e;
  endfunction

  // Box 2: rows 0..2, cols 6..8, row-major.
  function automatic logic [98:0] exp_box2();
    logic [98:0] e;
    e = '0;
    for (int k = 0; k < 9; k++) e[11*k +: 11] = bd[(k/3)*9 + 6 + (k%3)];
    return e;
  endfunction

  task automatic load_board(input bit solved, input bit gaps, input bit first_chk);
    for (int n = 0; n < 81; n++)
      bd[n] = solved ? {1'b0, 10'((((n/9)*3 + (n/9)/3 + n%9) % 9) + 1)} : 11'h400;
    for (int n = 0; n < 81; n++) begin
      if (gaps && (n == 40 || n == 80)) begin
        repeat (5) @(negedge clk);
        if (n == 80) check("gap_hold_busy", busy1, 0);
      end
      reading = 1'b1;
      data    = bd[n];
      @(negedge clk);
      reading = 1'b0;
      if (first_chk && n == 0) begin
        check("restart_done", done1, 0);
        check("restart_valid", valid1, 0);
        check("restart_bad", bad1, 31);
`ifdef SUDOKU_SEQ_FAIL_MASK_EN
        check("restart_mask", mask1, 0);
`endif
      end
    end
  endtask

  // Called at the negedge right after the last cell write; samples each negedge.
  task automatic run(input int budget, input bit poke);
    b0 = -1; b1 = -1; b3 = -1; d0 = -1; d1 = -1; d3 = -1;
    rq0 = 0; rq1 = 0; rq3 = 0; eg0 = 0; eg1 = 0; eg3 = 0; seqerr = 0;
    cap9 = '0; cap13 = '0; cap20 = '0;
    for (int c = 0; c < budget; c++) begin
      reading = 1'b0;
      if (busy0 && b0 < 0) b0 = c;
      if (busy1 && b1 < 0) b1 = c;
      if (busy3 && b3 < 0) b3 = c;
      if (done0 && d0 < 0) d0 = c;
      if (done1 && d1 < 0) d1 = c;
      if (done3 && d3 < 0) d3 = c;
      if (chk_req0) begin if (int'(grp_sel0) != eg0) seqerr++; eg0++; rq0++; end
      if (chk_req3) begin if (int'(grp_sel3) != eg3) seqerr++; eg3++; rq3++; end
      if (chk_req1) begin
        if (int'(grp_sel1) != eg1) seqerr++;
        eg1++; rq1++;
        if (grp_sel1 == 5'd9)  cap9  = grp_cells1;
        if (grp_sel1 == 5'd13) cap13 = grp_cells1;
        if (grp_sel1 == 5'd20) cap20 = grp_cells1;
      end
      if (poke && b1 >= 0 && (c == b1 + 3 || c == b1 + 9)) begin
        reading = 1'b1;
        data    = 11'h3ff;
      end
      @(negedge clk);
    end
    reading = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_valid", valid1, 0);
    check("rst_bad", bad1, 31);
    check("rst_req", chk_req1, 0);
    check("rst_sel", grp_sel1, 0);
    check("rst_cells", grp_cells1, empty_grp);
    rst_n = 1'b1;
    @(negedge clk);

    // Empty board, all groups pass, three latencies.
    load_board(0, 0, 0);
    run(140, 0);
    check("t1_lat0", d0 - b0, 27);
    check("t1_lat1", d1 - b1, 54);
    check("t1_lat3", d3 - b3, 108);
    check("t1_rq0", rq0, 27);
    check("t1_rq1", rq1, 27);
    check("t1_rq3", rq3, 27);
    check("t1_seq", seqerr, 0);
    check("t1_valid0", valid0, 1);
    check("t1_valid1", valid1, 1);
    check("t1_valid3", valid3, 1);
    check("t1_bad1", bad1, 31);
    check("t1_busy1", busy1, 0);

    // Solved grid with load gaps, started from DONE.
    load_board(1, 1, 1);
    run(140, 0);
    check("t2_col0", cap9, exp_col(0));
    check("t2_col4", cap13, exp_col(4));
    check("t2_box2", cap20, exp_box2());
    check("t2_lat1", d1 - b1, 54);
    check("t2_valid1", valid1, 1);
    check("t2_valid3", valid3, 1);

    // Group 12 fails on the CHK_LAT=1 unit.
    fail1 = 27'd1 << 12;
    load_board(0, 0, 0);
    run(140, 0);
`ifdef SUDOKU_SEQ_FAIL_MASK_EN
    check("t3_rq1", rq1, 27);
    check("t3_lat1", d1 - b1, 54);
    check("t3_mask", mask1, 27'h0001000);
`else
    check("t3_rq1", rq1, 13);
    check("t3_lat1", d1 - b1, 26);
`endif
    check("t3_done1", done1, 1);
    check("t3_valid1", valid1, 0);
    check("t3_bad1", bad1, 12);
    check("t3_valid0", valid0, 1);
    check("t3_seq", seqerr, 0);

    // Reset during WAIT of group 7.
    fail1 = '0;
    load_board(0, 0, 1);
    found = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (busy1 && !chk_req1 && grp_sel1 == 5'd7) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("t4_found_wait7", found, 1);
    rst_n = 1'b0;
    #1;
    check("t4_busy", busy1, 0);
    check("t4_req", chk_req1, 0);
    check("t4_sel", grp_sel1, 0);
    check("t4_bad", bad1, 31);
    check("t4_done", done1, 0);
    @(negedge clk);
    check("t4_cells", grp_cells1, empty_grp);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_board(1, 0, 0);
    run(140, 1);
    check("t4_rq1", rq1, 27);
    check("t4_lat1", d1 - b1, 54);
    check("t4_valid1", valid1, 1);
    check("t4_bad1", bad1, 31);
    check("t4_col0", cap9, exp_col(0));
    check("t4_col4", cap13, exp_col(4));
    check("t4_box2", cap20, exp_box2());

`ifdef SUDOKU_SEQ_FAIL_MASK_EN
    fail1 = (27'd1 << 3) | (27'd1 << 20);
    load_board(0, 0, 1);
    run(140, 0);
    check("m_rq1", rq1, 27);
    check("m_lat1", d1 - b1, 54);
    check("m_mask", mask1, 27'h0100008);
    check("m_valid", valid1, 0);
    check("m_bad", bad1, 3);
    check("m_mask0", mask0, 0);
    check("m_mask3", mask3, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
